// File: rtl/clap_pkg.sv
// Shared definitions for the clap counter: FSM state encoding and the
// clap-count values that select each command.
package clap_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      LISTEN = 2'd2,
      DECIDE = 2'd3
   } clap_state_t;

   localparam logic [1:0] CNT_STEP   = 2'd1;   // one clap: advance position
   localparam logic [1:0] CNT_TOGGLE = 2'd2;   // two claps: toggle active flag
   localparam logic [1:0] CNT_MAX    = 2'd3;   // three or more: ignored

   // Clap count increment that sticks at CNT_MAX
   function automatic logic [1:0] cnt_inc_sat(input logic [1:0] c);
      return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
   endfunction

endpackage

// File: rtl/clap_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for the sound sensor.
// An edge is only reported once the synchronised input has been seen low
// after reset, so a MIC level held high through reset release is not a clap.
module clap_edge_sync (
   input  logic CLK,
   input  logic RST,
   input  logic MIC,
   output logic clap_p
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic settle_reg;
   logic armed_reg;

   // Synchronise MIC, remember previous level, arm after a genuine low sample
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         prev_reg   <= 1'b0;
         settle_reg <= 1'b0;
         armed_reg  <= 1'b0;
      end else begin
         sync1_reg  <= MIC;
         sync2_reg  <= sync1_reg;
         prev_reg   <= sync2_reg;
         settle_reg <= 1'b1;
         // sync1_reg holds a real MIC sample only once settle_reg is set
         armed_reg  <= armed_reg | (settle_reg & ~sync1_reg);
      end
   end

   assign clap_p = sync2_reg & ~prev_reg & armed_reg;

endmodule

// File: rtl/clap_counter.sv
// Clap-command decoder: counts claps inside a window opened by the first
// clap, blanks echoes after each accepted clap, and applies the command
// (advance position / toggle active flag / ignore) one cycle after the
// window closes.
// Optional feature: define CLAP_AUTO_OFF_EN to switch the active flag off
// after IDLE_CYC cycles without a decided command.
module clap_counter
   import clap_pkg::*;
#(
   parameter int BLANK_CYC  = 5_000_000,
   parameter int WINDOW_CYC = 50_000_000,
   parameter int IDLE_CYC   = 1_500_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       MIC,
   output logic       cont_aplausos,
   output logic [1:0] lado,
   output logic       busy
);

   localparam int WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
   localparam int BLK_W = (BLANK_CYC > 1)  ? $clog2(BLANK_CYC)  : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

   // Reject parameter sets the counters cannot represent
   if (BLANK_CYC < 1 || WINDOW_CYC < 2 || IDLE_CYC < 1) begin : g_param_check
      $error("clap_counter: BLANK_CYC, WINDOW_CYC or IDLE_CYC out of range");
   end

   logic             clap_p;
   clap_state_t      state_reg;
   logic [1:0]       cnt_reg;
   logic [WIN_W-1:0] win_cnt_reg;
   logic [BLK_W-1:0] blank_cnt_reg;
   logic             cont_reg;
   logic [1:0]       lado_reg;
   logic             busy_reg;

`ifdef CLAP_AUTO_OFF_EN
   localparam int IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
   logic [IDLE_W-1:0] idle_cnt_reg;
`endif

   clap_edge_sync u_edge_sync (
      .CLK    (CLK),
      .RST    (RST),
      .MIC    (MIC),
      .clap_p (clap_p)
   );

   // Window FSM, counters and registered command outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= IDLE;
         cnt_reg       <= 2'd0;
         win_cnt_reg   <= '0;
         blank_cnt_reg <= '0;
         cont_reg      <= 1'b0;
         lado_reg      <= 2'd0;
         busy_reg      <= 1'b0;
`ifdef CLAP_AUTO_OFF_EN
         idle_cnt_reg  <= '0;
`endif
      end else begin
`ifdef CLAP_AUTO_OFF_EN
         // Inactivity timer runs only while active; a DECIDE restarts it
         // and overrides a coincident timeout.
         if (state_reg == DECIDE || !cont_reg || idle_cnt_reg == IDLE_LAST) begin
            idle_cnt_reg <= '0;
         end else begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
         end
         if (state_reg != DECIDE && cont_reg && idle_cnt_reg == IDLE_LAST) begin
            cont_reg <= 1'b0;
            lado_reg <= 2'd0;
         end
`endif
         case (state_reg)
            IDLE: begin
               if (clap_p) begin
                  cnt_reg       <= CNT_STEP;
                  win_cnt_reg   <= '0;
                  blank_cnt_reg <= '0;
                  state_reg     <= BLANK;
                  busy_reg      <= 1'b1;
               end
            end
            BLANK: begin
               // Window expiry has priority; claps are echoes here
               if (win_cnt_reg == WIN_LAST) begin
                  state_reg <= DECIDE;
               end else begin
                  win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                  if (blank_cnt_reg == BLK_LAST) begin
                     state_reg <= LISTEN;
                  end else begin
                     blank_cnt_reg <= blank_cnt_reg + BLK_W'(1);
                  end
               end
            end
            LISTEN: begin
               // A clap coinciding with expiry is dropped
               if (win_cnt_reg == WIN_LAST) begin
                  state_reg <= DECIDE;
               end else begin
                  win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                  if (clap_p) begin
                     cnt_reg       <= cnt_inc_sat(cnt_reg);
                     blank_cnt_reg <= '0;
                     state_reg     <= BLANK;
                  end
               end
            end
            DECIDE: begin
               if (cnt_reg == CNT_STEP) begin
                  if (cont_reg) begin
                     lado_reg <= lado_reg + 2'd1;
                  end
               end else if (cnt_reg == CNT_TOGGLE) begin
                  cont_reg <= ~cont_reg;
                  lado_reg <= 2'd0;
               end
               cnt_reg   <= 2'd0;
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign cont_aplausos = cont_reg;
   assign lado          = lado_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_clap_counter.sv
// Directed testbench for clap_counter with short blanking/window/idle times.
// A MIC edge driven before posedge P1 is accepted by the FSM at P3; the
// command lands 33 edges later, at P36.
module tb_clap_counter;

   localparam int BLANK_CYC  = 4;
   localparam int WINDOW_CYC = 32;
   localparam int IDLE_CYC   = 100;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       MIC = 1'b0;
   logic       cont_aplausos;
   logic [1:0] lado;
   logic       busy;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   logic busy_hist [0:127];

   always #5 CLK = ~CLK;

   clap_counter #(
      .BLANK_CYC  (BLANK_CYC),
      .WINDOW_CYC (WINDOW_CYC),
      .IDLE_CYC   (IDLE_CYC)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .MIC           (MIC),
      .cont_aplausos (cont_aplausos),
      .lado          (lado),
      .busy          (busy)
   );

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Drive MIC from a bit pattern, one bit per cycle; busy_hist[k] holds busy after k edges
   task automatic play(input logic [63:0] pat, input int n);
      for (int c = 0; c < n; c++) begin
         MIC = (c < 64) ? pat[c[5:0]] : 1'b0;
         @(negedge CLK);
         busy_hist[c+1] = busy;
      end
      MIC = 1'b0;
   endtask

   function automatic logic [63:0] pulse(input int c);
      logic [63:0] p;
      p = '0;
      p[c] = 1'b1;
      p[c+1] = 1'b1;
      return p;
   endfunction

   // One isolated clap and its command, then a short gap
   task automatic single_window(input logic exp_cont, input logic [1:0] exp_lado, input string name);
      play(pulse(0), 36);
      total_cnt++;
      if (cont_aplausos !== exp_cont || lado !== exp_lado)
         $display("FAIL %s: cont_aplausos=%b lado=%0d, expected cont_aplausos=%b lado=%0d",
                  name, cont_aplausos, lado, exp_cont, exp_lado);
      else pass_cnt++;
      $display("window %s: cont_aplausos=%b lado=%0d busy=%b", name, cont_aplausos, lado, busy);
      step(2);
   endtask

   task automatic test_reset();
      int highs;
      RST = 1'b1;
      MIC = 1'b1;
      step(3);
      total_cnt++;
      if ({cont_aplausos, lado, busy} !== 4'b0000)
         $display("FAIL reset_state: cont/lado/busy=%b, expected 0000", {cont_aplausos, lado, busy});
      else pass_cnt++;
      RST = 1'b0;
      highs = 0;
      play('1, 12);
      for (int k = 1; k <= 12; k++) if (busy_hist[k] !== 1'b0) highs++;
      play('0, 20);
      for (int k = 1; k <= 20; k++) if (busy_hist[k] !== 1'b0) highs++;
      total_cnt++;
      if (highs !== 0)
         $display("FAIL mic_high_at_release: busy high in %0d cycles, expected 0", highs);
      else pass_cnt++;
      total_cnt++;
      if ({cont_aplausos, lado} !== 3'b000)
         $display("FAIL mic_high_outputs: cont/lado=%b, expected 000", {cont_aplausos, lado});
      else pass_cnt++;
      $display("reset: cont_aplausos=%b lado=%0d busy=%b", cont_aplausos, lado, busy);
   endtask

   task automatic test_two_claps();
      int bad;
      play(pulse(0) | pulse(10), 35);
      total_cnt++;
      if (cont_aplausos !== 1'b0)
         $display("FAIL two_claps_early: cont_aplausos=%b after 35 edges, expected 0", cont_aplausos);
      else pass_cnt++;
      total_cnt++;
      if (busy_hist[2] !== 1'b0)
         $display("FAIL busy_before_accept: busy=%b, expected 0", busy_hist[2]);
      else pass_cnt++;
      bad = 0;
      for (int k = 3; k <= 35; k++) if (busy_hist[k] !== 1'b1) bad++;
      total_cnt++;
      if (bad !== 0)
         $display("FAIL busy_throughout: busy low in %0d cycles, expected 0", bad);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (cont_aplausos !== 1'b1 || lado !== 2'd0)
         $display("FAIL two_claps_toggle: cont_aplausos=%b lado=%0d, expected 1 and 0", cont_aplausos, lado);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0)
         $display("FAIL busy_after_decide: busy=%b, expected 0", busy);
      else pass_cnt++;
      $display("two_claps: cont_aplausos=%b lado=%0d busy=%b", cont_aplausos, lado, busy);
      step(2);
   endtask

   task automatic test_bounce();
      // Rising edges at cycles 0, 2 and 4: the later two fall in blanking
      play(64'h15, 36);
      total_cnt++;
      if (cont_aplausos !== 1'b1 || lado !== 2'd1)
         $display("FAIL bounce_single: cont_aplausos=%b lado=%0d, expected 1 and 1", cont_aplausos, lado);
      else pass_cnt++;
      $display("bounce: cont_aplausos=%b lado=%0d", cont_aplausos, lado);
      step(2);
   endtask

   task automatic test_wrap();
      single_window(1'b1, 2'd2, "step_to_2");
      single_window(1'b1, 2'd3, "step_to_3");
      single_window(1'b1, 2'd0, "wrap_3_to_0");
      single_window(1'b1, 2'd1, "step_to_1");
   endtask

   task automatic test_reset_mid_window();
      int highs;
      play(pulse(0) | pulse(10), 20);
      total_cnt++;
      if (busy !== 1'b1)
         $display("FAIL mid_window_busy: busy=%b, expected 1", busy);
      else pass_cnt++;
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      total_cnt++;
      if ({cont_aplausos, lado, busy} !== 4'b0000)
         $display("FAIL reset_mid_window: cont/lado/busy=%b, expected 0000", {cont_aplausos, lado, busy});
      else pass_cnt++;
      play('0, 45);
      highs = 0;
      for (int k = 1; k <= 45; k++) if (busy_hist[k] !== 1'b0) highs++;
      total_cnt++;
      if (cont_aplausos !== 1'b0 || highs !== 0)
         $display("FAIL no_toggle_after_reset: cont_aplausos=%b busy_high_cycles=%0d, expected 0 and 0",
                  cont_aplausos, highs);
      else pass_cnt++;
      $display("reset_mid_window: cont_aplausos=%b lado=%0d", cont_aplausos, lado);
   endtask

   task automatic test_single_inactive();
      single_window(1'b0, 2'd0, "single_while_off");
   endtask

   task automatic test_saturate();
      play(pulse(0) | pulse(6) | pulse(12) | pulse(18) | pulse(32), 36);
      total_cnt++;
      if (cont_aplausos !== 1'b0 || lado !== 2'd0)
         $display("FAIL saturate_outputs: cont_aplausos=%b lado=%0d, expected 0 and 0", cont_aplausos, lado);
      else pass_cnt++;
      total_cnt++;
      if (busy_hist[35] !== 1'b1 || busy !== 1'b0)
         $display("FAIL saturate_decide: busy at edge 35=%b at edge 36=%b, expected 1 and 0", busy_hist[35], busy);
      else pass_cnt++;
      step(5);
      total_cnt++;
      if (busy !== 1'b0)
         $display("FAIL saturate_idle: busy=%b, expected 0", busy);
      else pass_cnt++;
      $display("saturate: cont_aplausos=%b lado=%0d busy=%b", cont_aplausos, lado, busy);
   endtask

   task automatic test_auto_off();
      play(pulse(0) | pulse(10), 36);
      step(2);
      single_window(1'b1, 2'd1, "arm_for_idle");
      // Last DECIDE closed 2 edges ago; idle timer is now 2
      step(97);
      total_cnt++;
      if (cont_aplausos !== 1'b1 || lado !== 2'd1)
         $display("FAIL idle_before_timeout: cont_aplausos=%b lado=%0d, expected 1 and 1", cont_aplausos, lado);
      else pass_cnt++;
      step(1);
`ifdef CLAP_AUTO_OFF_EN
      total_cnt++;
      if (cont_aplausos !== 1'b0 || lado !== 2'd0)
         $display("FAIL auto_off: cont_aplausos=%b lado=%0d, expected 0 and 0", cont_aplausos, lado);
      else pass_cnt++;
`else
      total_cnt++;
      if (cont_aplausos !== 1'b1 || lado !== 2'd1)
         $display("FAIL no_auto_off: cont_aplausos=%b lado=%0d, expected 1 and 1", cont_aplausos, lado);
      else pass_cnt++;
`endif
      step(20);
      total_cnt++;
`ifdef CLAP_AUTO_OFF_EN
      if (cont_aplausos !== 1'b0)
         $display("FAIL auto_off_hold: cont_aplausos=%b, expected 0", cont_aplausos);
      else pass_cnt++;
`else
      if (cont_aplausos !== 1'b1)
         $display("FAIL no_auto_off_hold: cont_aplausos=%b, expected 1", cont_aplausos);
      else pass_cnt++;
`endif
      $display("auto_off: cont_aplausos=%b lado=%0d", cont_aplausos, lado);
   endtask

   initial begin
      test_reset();
      test_two_claps();
      test_bounce();
      test_wrap();
      test_reset_mid_window();
      test_single_inactive();
      test_saturate();
      test_auto_off();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/clap_counter.md
CLAP_COUNTER -- requirements
Module: clap_counter

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 5_000_000, echo-blanking time after each accepted clap (100 ms at 50 MHz).
REQ-002 SHALL have parameter WINDOW_CYC, default 50_000_000, length of the clap-collection window, counted from the first clap (1 s).
REQ-003 SHALL have parameter IDLE_CYC, default 1_500_000_000, auto-off timeout (30 s); used only under CLAP_AUTO_OFF_EN.
REQ-004 SHALL have port CLK  input  1  system clock, 50 MHz.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port MIC  input  1  asynchronous digital output of the sound sensor; high = sound.
REQ-007 SHALL have port cont_aplausos  output  1  registered; servo/laser active flag to the downstream servo stage.
REQ-008 SHALL have port lado  output  2  registered; selected position index, 0..3.
REQ-009 SHALL have port busy  output  1  registered; high while a window is open (any state other than IDLE).

Function
REQ-010 SHALL synchronise MIC through two flip-flops, then rising-edge detect it into a 1-cycle pulse clap_p.
REQ-011 SHALL use FSM states IDLE, BLANK, LISTEN and DECIDE.
REQ-012 IDLE: clap_p -> cnt=1, win_cnt=0, blank_cnt=0, next state BLANK.
REQ-013 BLANK: win_cnt and blank_cnt increment each cycle; clap_p ignored; blank_cnt==BLANK_CYC-1 -> LISTEN.
REQ-014 LISTEN: win_cnt increments; clap_p -> cnt+1 saturating at 3, blank_cnt=0, next state BLANK.
REQ-015 In BLANK or LISTEN, win_cnt==WINDOW_CYC-1 -> DECIDE; expiry wins over a coincident clap_p, and that clap is dropped.
REQ-016 DECIDE lasts exactly one cycle, applies the command at its closing edge, then returns to IDLE.
REQ-017 DECIDE with cnt==1: if cont_aplausos=1, lado <= lado+1 with wrap 3->0; if cont_aplausos=0, no change.
REQ-018 DECIDE with cnt==2: cont_aplausos toggles and lado <= 0.
REQ-019 DECIDE with cnt==3 (three or more claps): no output change.
REQ-020 A clap_p arriving in DECIDE SHALL be ignored.
REQ-021 Latency: outputs SHALL change exactly WINDOW_CYC+1 cycles after the cycle in which IDLE accepted clap_p.
REQ-022 Counter widths SHALL be sized with $clog2 of their parameters; no counter SHALL wrap within its limit.
REQ-023 busy SHALL be 1 in BLANK, LISTEN and DECIDE, and 0 in IDLE.

Reset
REQ-024 RST=1 at a clock edge SHALL force: state IDLE, cnt=0, all counters 0, sync flops 0, cont_aplausos=0, lado=0, busy=0.
REQ-025 RST SHALL take effect in any state, including mid-window; the partial clap count is discarded and no command is applied.
REQ-026 A MIC level held high through reset release SHALL NOT produce clap_p.

Configuration
REQ-027 Macro CLAP_AUTO_OFF_EN, when defined, SHALL add idle_cnt: cleared on every DECIDE and whenever cont_aplausos=0, incremented otherwise.
REQ-028 With CLAP_AUTO_OFF_EN, idle_cnt==IDLE_CYC-1 SHALL clear cont_aplausos and lado to 0 on the next edge.
REQ-029 With CLAP_AUTO_OFF_EN, a DECIDE on the same cycle as the timeout SHALL take priority over the timeout.
REQ-030 Without CLAP_AUTO_OFF_EN, no idle counter SHALL exist and cont_aplausos SHALL change only in DECIDE or on reset.

Structure
REQ-031 Package clap_pkg SHALL hold the FSM state encoding and the count constants CNT_STEP=1, CNT_TOGGLE=2 and CNT_MAX=3.
REQ-032 Sub-module clap_edge_sync SHALL contain the 2-FF synchroniser and rising-edge detector (MIC in, clap_p out).
REQ-033 All other logic SHALL reside in clap_counter.

Verification
REQ-034 The bench SHALL use BLANK_CYC=4, WINDOW_CYC=32 and IDLE_CYC=100, and SHALL cover at least the following scenarios:
REQ-035 Two clean pulses 10 cycles apart from reset -> cont_aplausos 0->1 and lado=0, exactly 33 cycles after the first clap_p; busy high throughout.
REQ-036 With cont_aplausos=1 and lado=3, one clap -> lado=0; with cont_aplausos=0, one clap -> no change.
REQ-037 MIC bouncing 3 times within 4 cycles of the first edge -> cnt stays 1, treated as a single clap.
REQ-038 Four claps spaced 6 cycles, with a fifth coinciding with win_cnt==31 -> cnt saturates at 3, outputs unchanged, state returns to IDLE.
REQ-039 RST pulsed in LISTEN with cnt=2 -> all outputs 0 on the next edge and no toggle afterwards.
REQ-040 With CLAP_AUTO_OFF_EN and cont_aplausos=1, no clap for 100 cycles -> cont_aplausos=0 and lado=0; without the macro -> cont_aplausos remains 1.
